relu_maxpool2_stream: RTL and testbench
=======================================

Name: relu_maxpool2_stream

Overview:
- Downstream stage of the Conv2 block. Consumes its requantized int8 per-filter output stream, ordered filter-fastest, then x, then y.
- Applies ReLU, then 2x2 stride-2 max pooling per channel: 14x14xCH in, 7x7xCH out.
- Emits a tagged int8 stream with valid/ready handshake, which feeds flatten/FC.
- Holds one pooled row of partial maxima, so no full-frame buffer is needed.

Parameters:
- CH, 32, channels (Conv2 filters) interleaved on the stream
- IN_H, 14, input map height
- IN_W, 14, input map width
- DATA_W, 8, signed pixel width
- OUT_H, IN_H/2, pooled height (floor; derived)
- OUT_W, IN_W/2, pooled width (floor; derived)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous active-low reset (rst=0 resets)
- in_data  in  DATA_W  signed requantized pixel
- in_valid  in  1  in_data and tags valid
- in_ready  out  1  beat accepted when in_valid&&in_ready
- in_ch  in  $clog2(CH)  filter tag
- in_y  in  $clog2(IN_H)  row tag
- in_x  in  $clog2(IN_W)  column tag
- out_data  out  DATA_W  pooled pixel, always >=0
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_ch  out  $clog2(CH)  channel of out_data
- out_y  out  $clog2(OUT_H)  pooled row
- out_x  out  $clog2(OUT_W)  pooled column
- frame_done  out  1  one-cycle pulse with the handshake of the last pooled beat (ch=CH-1, y=OUT_H-1, x=OUT_W-1)
- seq_err  out  1  sticky: an accepted tag differed from expected position

Behaviour:
- Reset (async, rst=0): out_valid=0, out_data=0, all out tags=0, frame_done=0, seq_err=0, position counters=0. Buffer contents are don't-care (always overwritten before being read).
- Position counters: internal c (0..CH-1), x (0..IN_W-1), y (0..IN_H-1) advance on each accepted beat.
  - c fastest; c wraps to 0 and increments x; x wraps to 0 and increments y; y wraps to 0 after the full frame.
  - Addressing uses the internal counters only. Tags are checked, not used.
  - If an accepted {in_ch,in_y,in_x} != {c,y,x}, seq_err is set and stays set until reset. Processing continues on the counters.
- ReLU: v = in_data<0 ? 0 : in_data, computed as a signed compare.
- Partial buffer: OUT_W*CH entries of DATA_W, addressed (x>>1)*CH+c. Combinational read, write on accept, so one beat per cycle with no stall.
- Per accepted beat, with m = max(buf[addr], v):
  - y even, x even: buf = v.
  - y even, x odd: buf = m.
  - y odd, x even: buf = m.
  - y odd, x odd: no write; load the output register with out_data=m, out_ch=c, out_y=y>>1, out_x=x>>1, out_valid=1.
  - Odd IN_H/IN_W: beats at y==IN_H-1 (IN_H odd) or x==IN_W-1 (IN_W odd) are accepted and counted but neither write nor emit (floor pooling).
- Latency: the output is registered, 1 cycle after the accept of the 4th window element.
- Handshake:
  - in_ready = !out_valid || out_ready, combinational.
  - out_valid drops after the output handshake unless a new result loads in the same cycle.
  - out_data and tags hold stable while out_valid && !out_ready.
  - Full throughput is maintained with out_ready held high.
- Simultaneous events: an output handshake and a new result load in the same cycle keeps out_valid=1 with the new data.
- frame_done is asserted combinationally as out_valid && out_ready && the output is the last pooled beat.
- A reset mid-frame discards partial maxima and the pending output. The next accepted beat is treated as (c,x,y)=(0,0,0).

Test Plan:
- Use CH=2, IN_H=IN_W=4, out_ready=1. Drive an in-order ramp where pixel value = 4*y+x for ch0 and its negation for ch1. Required: 8 outputs, ch0 values 5, 7, 13, 15, ch1 all 0, and frame_done on the 8th beat.
- All inputs -128. Required: every output is 0 (ReLU before pooling), seq_err=0.
- Window {3, 127, -5, 100}, max at the 2nd element. Required: out_data=127, out_x=0, out_y=0, one cycle after the 4th accept.
- Hold out_ready=0 after the first output. Required: in_ready=0, the output holds stable, and no beats are lost; on release the full 8-output sequence matches scenario 1.
- Inject a beat with in_x=2 where 1 is expected. Required: seq_err rises on that accept, stays high, and the output values are still computed from the counters.
- IN_H=IN_W=5, ramp input. Required: 2x2 pooled outputs per channel, row 4 and column 4 ignored, and frame_done after 8 outputs; assert rst=0 mid-frame, then restart and get clean results.

Source files
------------

// File: rtl/relu_maxpool2_stream_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : relu_maxpool2_stream_if
// Description : Tagged int8 pixel stream: data, valid/ready and ch/y/x tags.
// Revision    : 1.0 - initial release
// ============================================================================
interface relu_maxpool2_stream_if #(
    parameter int DATA_W = 8,
    parameter int CH_W   = 5,
    parameter int Y_W    = 4,
    parameter int X_W    = 4
);
    logic signed [DATA_W-1:0] data;
    logic                     valid;
    logic                     ready;
    logic [CH_W-1:0]          ch;
    logic [Y_W-1:0]           y;
    logic [X_W-1:0]           x;

    modport master (output data, valid, ch, y, x, input ready);
    modport slave  (input data, valid, ch, y, x, output ready);
endinterface
`default_nettype wire

// File: rtl/relu_maxpool2_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : relu_maxpool2_stream
// Description : ReLU followed by 2x2/2 max pooling on a channel-interleaved
//               stream, keeping one pooled row of partial maxima.
// Revision    : 1.0 - initial release
// ============================================================================
module relu_maxpool2_stream #(
    parameter int CH     = 32,
    parameter int IN_H   = 14,
    parameter int IN_W   = 14,
    parameter int DATA_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    relu_maxpool2_stream_if.slave         s_in,
    relu_maxpool2_stream_if.master        m_out,
    output logic                          frame_done,
    output logic                          seq_err
);

    localparam int OUT_H  = IN_H / 2;
    localparam int OUT_W  = IN_W / 2;
    localparam int CH_W   = (CH    > 1) ? $clog2(CH)    : 1;
    localparam int Y_W    = (IN_H  > 1) ? $clog2(IN_H)  : 1;
    localparam int X_W    = (IN_W  > 1) ? $clog2(IN_W)  : 1;
    localparam int OY_W   = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int OX_W   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int DEPTH  = OUT_W * CH;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam bit H_ODD = (IN_H % 2) == 1;
    localparam bit W_ODD = (IN_W % 2) == 1;

    localparam logic [CH_W-1:0] C_LAST_C  = CH_W'(CH - 1);
    localparam logic [Y_W-1:0]  C_LAST_Y  = Y_W'(IN_H - 1);
    localparam logic [X_W-1:0]  C_LAST_X  = X_W'(IN_W - 1);
    localparam logic [OY_W-1:0] C_LAST_OY = OY_W'(OUT_H - 1);
    localparam logic [OX_W-1:0] C_LAST_OX = OX_W'(OUT_W - 1);
    localparam logic signed [DATA_W-1:0] C_ZERO = '0;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CH_W-1:0]          c_q,         c_d;
    logic [Y_W-1:0]           y_q,         y_d;
    logic [X_W-1:0]           x_q,         x_d;
    logic                     seq_err_q,   seq_err_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_data_q,  out_data_d;
    logic [CH_W-1:0]          out_ch_q,    out_ch_d;
    logic [OY_W-1:0]          out_y_q,     out_y_d;
    logic [OX_W-1:0]          out_x_q,     out_x_d;

    logic signed [DATA_W-1:0] buf_q [DEPTH];

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic                     w_accept;
    logic                     w_pool_ok;
    logic [ADDR_W-1:0]        w_addr;
    logic signed [DATA_W-1:0] w_relu;
    logic signed [DATA_W-1:0] w_rd;
    logic signed [DATA_W-1:0] w_max;
    logic                     w_tag_err;
    logic                     buf_we;
    logic signed [DATA_W-1:0] buf_wd;
    logic                     w_emit;

    assign s_in.ready = !out_valid_q || m_out.ready;
    assign w_accept   = s_in.valid && s_in.ready;

    // The trailing row/column of an odd-sized map has no pooling partner.
    assign w_pool_ok = !(H_ODD && (y_q == C_LAST_Y)) && !(W_ODD && (x_q == C_LAST_X));

    assign w_addr    = w_pool_ok ? ADDR_W'(int'(x_q >> 1) * CH + int'(c_q)) : '0;
    assign w_relu    = (s_in.data < C_ZERO) ? C_ZERO : s_in.data;
    assign w_rd      = buf_q[w_addr];
    assign w_max     = (w_rd > w_relu) ? w_rd : w_relu;
    assign w_tag_err = (s_in.ch != c_q) || (s_in.y != y_q) || (s_in.x != x_q);

    always_comb begin
        buf_we = 1'b0;
        buf_wd = w_relu;
        w_emit = 1'b0;
        if (w_accept && w_pool_ok) begin
            unique case ({y_q[0], x_q[0]})
                2'b00: begin
                    buf_we = 1'b1;
                    buf_wd = w_relu;
                end
                2'b01, 2'b10: begin
                    buf_we = 1'b1;
                    buf_wd = w_max;
                end
                default: w_emit = 1'b1;
            endcase
        end
    end

    // Position counters: channel fastest, then column, then row.
    always_comb begin
        c_d = c_q;
        x_d = x_q;
        y_d = y_q;
        if (w_accept) begin
            if (c_q == C_LAST_C) begin
                c_d = '0;
                if (x_q == C_LAST_X) begin
                    x_d = '0;
                    y_d = (y_q == C_LAST_Y) ? '0 : y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end else begin
                c_d = c_q + 1'b1;
            end
        end
    end

    always_comb begin
        seq_err_d   = seq_err_q || (w_accept && w_tag_err);
        out_valid_d = out_valid_q && !m_out.ready;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_y_d     = out_y_q;
        out_x_d     = out_x_q;
        if (w_emit) begin
            out_valid_d = 1'b1;
            out_data_d  = w_max;
            out_ch_d    = c_q;
            out_y_d     = OY_W'(y_q >> 1);
            out_x_d     = OX_W'(x_q >> 1);
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_q         <= '0;
            y_q         <= '0;
            x_q         <= '0;
            seq_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_y_q     <= '0;
            out_x_q     <= '0;
        end else begin
            c_q         <= c_d;
            y_q         <= y_d;
            x_q         <= x_d;
            seq_err_q   <= seq_err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_y_q     <= out_y_d;
            out_x_q     <= out_x_d;
        end
    end

    // Partial maxima: every entry is written at (even y, even x) before any read.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[w_addr] <= buf_wd;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign m_out.valid = out_valid_q;
    assign m_out.data  = out_data_q;
    assign m_out.ch    = out_ch_q;
    assign m_out.y     = out_y_q;
    assign m_out.x     = out_x_q;
    assign seq_err     = seq_err_q;

    assign frame_done = out_valid_q && m_out.ready && (out_ch_q == C_LAST_C) &&
                        (out_y_q == C_LAST_OY) && (out_x_q == C_LAST_OX);

endmodule
`default_nettype wire

// File: tb/tb_relu_maxpool2_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_relu_maxpool2_stream
// Description : Scoreboard bench; dut_a is CH=2 4x4, dut_b is CH=2 5x5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_relu_maxpool2_stream;

    typedef struct {
        int data;
        int ch;
        int y;
        int x;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    logic a_done, a_err, b_done, b_err;

    relu_maxpool2_stream_if #(.DATA_W(8), .CH_W(1), .Y_W(2), .X_W(2)) a_in ();
    relu_maxpool2_stream_if #(.DATA_W(8), .CH_W(1), .Y_W(1), .X_W(1)) a_out ();
    relu_maxpool2_stream_if #(.DATA_W(8), .CH_W(1), .Y_W(3), .X_W(3)) b_in ();
    relu_maxpool2_stream_if #(.DATA_W(8), .CH_W(1), .Y_W(1), .X_W(1)) b_out ();

    relu_maxpool2_stream #(.CH(2), .IN_H(4), .IN_W(4), .DATA_W(8)) dut_a (
        .clk(clk), .rst(rst_a), .s_in(a_in), .m_out(a_out),
        .frame_done(a_done), .seq_err(a_err)
    );

    relu_maxpool2_stream #(.CH(2), .IN_H(5), .IN_W(5), .DATA_W(8)) dut_b (
        .clk(clk), .rst(rst_b), .s_in(b_in), .m_out(b_out),
        .frame_done(b_done), .seq_err(b_err)
    );

    exp_t qa[$];
    exp_t qb[$];
    int   pix [2][2][5][5];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt [2];
    int   out_cnt  [2];

    task automatic check_eq(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    endtask

    task automatic mon(input int sel, input int d, input int ch, input int y,
                       input int x, input int fd);
        exp_t e;
        out_cnt[sel]++;
        if (sel == 0) begin
            check_eq("a_out_expected", int'(qa.size() != 0), 1);
            if (qa.size() == 0) return;
            e = qa.pop_front();
        end else begin
            check_eq("b_out_expected", int'(qb.size() != 0), 1);
            if (qb.size() == 0) return;
            e = qb.pop_front();
        end
        check_eq("out_data",   d,  e.data);
        check_eq("out_ch",     ch, e.ch);
        check_eq("out_y",      y,  e.y);
        check_eq("out_x",      x,  e.x);
        check_eq("frame_done", fd, int'(e.last));
    endtask

    always @(negedge clk) begin
        if (rst_a && a_out.valid && a_out.ready)
            mon(0, int'(a_out.data), int'(a_out.ch), int'(a_out.y), int'(a_out.x), int'(a_done));
        if (a_done) done_cnt[0]++;
        if (rst_b && b_out.valid && b_out.ready)
            mon(1, int'(b_out.data), int'(b_out.ch), int'(b_out.y), int'(b_out.x), int'(b_done));
        if (b_done) done_cnt[1]++;
    end

    // Drive one beat at model position (py,px,pc) with tags (ty,tx,tc).
    task automatic drive(input int sel, input int py, input int px, input int pc,
                         input int ty, input int tx, input int tc, input int d);
        int   n;
        bit   ok;
        int   hw;
        exp_t e;
        if (sel == 0) begin
            a_in.data = 8'(d); a_in.ch = 1'(tc); a_in.y = 2'(ty); a_in.x = 2'(tx);
            a_in.valid = 1'b1;
        end else begin
            b_in.data = 8'(d); b_in.ch = 1'(tc); b_in.y = 3'(ty); b_in.x = 3'(tx);
            b_in.valid = 1'b1;
        end
        n  = 0;
        ok = 1'b0;
        while (!ok && n <= 200) begin
            @(negedge clk);
            if ((sel == 0) ? a_in.ready : b_in.ready) ok = 1'b1;
            else n++;
        end
        if (!ok) check_eq("in_ready_timeout", n, 0);
        @(posedge clk);
        #1;
        if (sel == 0) a_in.valid = 1'b0;
        else          b_in.valid = 1'b0;

        pix[sel][pc][py][px] = (d < 0) ? 0 : d;
        hw = (sel == 0) ? 2 : 2;
        if ((py % 2) == 1 && (px % 2) == 1 && (py / 2) < hw && (px / 2) < hw) begin
            e.data = pix[sel][pc][py-1][px-1];
            if (pix[sel][pc][py-1][px] > e.data) e.data = pix[sel][pc][py-1][px];
            if (pix[sel][pc][py][px-1] > e.data) e.data = pix[sel][pc][py][px-1];
            if (pix[sel][pc][py][px]   > e.data) e.data = pix[sel][pc][py][px];
            e.ch   = pc;
            e.y    = py / 2;
            e.x    = px / 2;
            e.last = (pc == 1) && (e.y == hw - 1) && (e.x == hw - 1);
            if (sel == 0) qa.push_back(e);
            else          qb.push_back(e);
        end
    endtask

    // mode 0: ramp (ch0 = 4y+x, ch1 = -(4y+x)); 1: all -128; 2: single window
    task automatic drive_frame(input int sel, input int mode, input int max_beats,
                               input bit bad_tag);
        int dim, nb, d, tx;
        dim = (sel == 0) ? 4 : 5;
        nb  = 0;
        for (int y = 0; y < dim; y++) begin
            for (int x = 0; x < dim; x++) begin
                for (int c = 0; c < 2; c++) begin
                    if (nb == max_beats) return;
                    case (mode)
                        0:       d = (c == 0) ? (4 * y + x) : -(4 * y + x);
                        1:       d = -128;
                        default: begin
                            d = 0;
                            if (c == 0 && y == 0 && x == 0) d = 3;
                            if (c == 0 && y == 0 && x == 1) d = 127;
                            if (c == 0 && y == 1 && x == 0) d = -5;
                            if (c == 0 && y == 1 && x == 1) d = 100;
                        end
                    endcase
                    tx = x;
                    if (bad_tag && c == 0 && y == 0 && x == 1) begin
                        tx = 2;
                        check_eq("seq_err_pre", int'(a_err), 0);
                    end
                    drive(sel, y, x, c, y, tx, c, d);
                    nb++;
                    if (bad_tag && c == 0 && y == 0 && x == 1)
                        check_eq("seq_err_rise", int'(a_err), 1);
                    if (mode == 2 && sel == 0 && c == 0 && y == 1 && x == 1) begin
                        check_eq("win_valid", int'(a_out.valid), 1);
                        check_eq("win_data",  int'(a_out.data), 127);
                        check_eq("win_x",     int'(a_out.x), 0);
                        check_eq("win_y",     int'(a_out.y), 0);
                    end
                end
            end
        end
    endtask

    task automatic drain_check(input int sel, input int exp_done, input int exp_outs);
        repeat (4) @(posedge clk);
        #1;
        check_eq("q_drained", (sel == 0) ? qa.size() : qb.size(), 0);
        check_eq("frame_done_count", done_cnt[sel], exp_done);
        check_eq("output_count", out_cnt[sel], exp_outs);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int hold_d, hold_ch, hold_x, k;
        bit seen;
        a_in.valid = 1'b0; a_in.data = '0; a_in.ch = '0; a_in.y = '0; a_in.x = '0;
        b_in.valid = 1'b0; b_in.data = '0; b_in.ch = '0; b_in.y = '0; b_in.x = '0;
        a_out.ready = 1'b1;
        b_out.ready = 1'b1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid",  int'(a_out.valid), 0);
        check_eq("rst_out_data",   int'(a_out.data), 0);
        check_eq("rst_out_tags",   int'({a_out.ch, a_out.y, a_out.x}), 0);
        check_eq("rst_frame_done", int'(a_done), 0);
        check_eq("rst_seq_err",    int'(a_err), 0);
        check_eq("rst_in_ready",   int'(a_in.ready), 1);
        check_eq("rst_b_valid",    int'(b_out.valid), 0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(posedge clk);
        #1;

        // In-order ramp
        drive_frame(0, 0, 1000, 1'b0);
        drain_check(0, 1, 8);

        // All -128: ReLU clamps everything to zero
        drive_frame(0, 1, 1000, 1'b0);
        drain_check(0, 2, 16);
        check_eq("neg_seq_err", int'(a_err), 0);

        // Single window with the max in the 2nd element
        drive_frame(0, 2, 1000, 1'b0);
        drain_check(0, 3, 24);

        // Backpressure after the first output
        fork
            drive_frame(0, 0, 1000, 1'b0);
            begin
                k = 0;
                seen = 1'b0;
                while (!seen && k <= 200) begin
                    @(negedge clk);
                    if (a_out.valid && a_out.ready) seen = 1'b1;
                    else k++;
                end
                if (!seen) check_eq("bp_first_out_timeout", k, 0);
                @(posedge clk);
                #1;
                a_out.ready = 1'b0;
                hold_d  = int'(a_out.data);
                hold_ch = int'(a_out.ch);
                hold_x  = int'(a_out.x);
                check_eq("bp_valid_held", int'(a_out.valid), 1);
                repeat (6) begin
                    @(negedge clk);
                    check_eq("bp_in_ready", int'(a_in.ready), 0);
                    check_eq("bp_data_stable", int'(a_out.data), hold_d);
                    check_eq("bp_tag_stable", int'(a_out.ch) * 2 + int'(a_out.x), hold_ch * 2 + hold_x);
                end
                @(posedge clk);
                #1;
                a_out.ready = 1'b1;
            end
        join
        drain_check(0, 4, 32);

        // Wrong tag: sticky seq_err, values still from the counters
        drive_frame(0, 0, 1000, 1'b1);
        drain_check(0, 5, 40);
        check_eq("seq_err_sticky", int'(a_err), 1);
        rst_a = 1'b0;
        #1;
        check_eq("seq_err_cleared", int'(a_err), 0);
        @(posedge clk);
        #1;
        rst_a = 1'b1;

        // 5x5 map: floor pooling ignores row 4 and column 4
        drive_frame(1, 0, 1000, 1'b0);
        drain_check(1, 1, 8);

        // Mid-frame reset right after the first window result loads
        drive_frame(1, 0, 13, 1'b0);
        check_eq("b_pending_pre_rst", int'(b_out.valid), 1);
        rst_b = 1'b0;
        #1;
        check_eq("b_rst_valid", int'(b_out.valid), 0);
        qb.delete();
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        drive_frame(1, 0, 1000, 1'b0);
        drain_check(1, 2, 16);
        check_eq("b_seq_err", int'(b_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
